lsu_sequencer: RTL and testbench

Load/store sequencer between the single-cycle core's decode/execute stage and the word-organized data memory port. It accepts one load or store per handshake and converts funct3 width/sign plus the byte address into word-aligned memory beats with byte strobes. It returns sign- or zero-extended load data, and splits accesses that straddle a word boundary into two beats. The core holds its PC while a request is outstanding.

---
 rtl/lsu_sequencer.sv | 241 ++++++++++++++++++++++++
 tb/tb_lsu_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/lsu_sequencer.sv
`default_nettype none
// ============================================================================
// lsu_sequencer : load/store to word-memory beat sequencer (LSU_MISALIGNED_SPLIT_EN)
// Revision 1.0
// ============================================================================
module lsu_sequencer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [2:0]        i_req_funct3,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [3:0]        o_mem_strb,
  input  logic              i_mem_gnt,
  input  logic              i_mem_rvalid,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_BEAT0 = 3'd1;
  localparam logic [2:0] c_WAIT0 = 3'd2;
  localparam logic [2:0] c_RESP  = 3'd3;
`ifdef LSU_MISALIGNED_SPLIT_EN
  localparam logic [2:0] c_BEAT1 = 3'd4;
  localparam logic [2:0] c_WAIT1 = 3'd5;
`else
  localparam logic [2:0] c_FAULT = 3'd6;
`endif

  logic [2:0]        r_state;
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [ADDR_W-3:0] r_base;
  logic [1:0]        r_off;
  logic [31:0]       r_wdata0;
  logic [3:0]        r_strb0;
  logic              r_err;
  logic [31:0]       r_beat0;

  logic              w_accept;
  logic              w_legal;
  logic [3:0]        w_mask;
  logic [7:0]        w_strb8;
  logic              w_split;
  logic [4:0]        w_shamt;
  logic [4:0]        w_rshamt;
  logic [31:0]       w_wdata0;
  logic [31:0]       w_word;
  logic [31:0]       w_ext;

  assign o_req_ready = (r_state == c_IDLE);
  assign w_accept    = i_req_valid & o_req_ready;
  assign w_shamt     = {i_req_addr[1:0], 3'b000};
  assign w_rshamt    = {r_off, 3'b000};

  always_comb begin
    w_mask = 4'b1111;
    case (i_req_funct3[1:0])
      2'b00:   w_mask = 4'b0001;
      2'b01:   w_mask = 4'b0011;
      default: w_mask = 4'b1111;
    endcase
  end

  always_comb begin
    w_legal = 1'b0;
    case (i_req_funct3)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b100, 3'b101:         w_legal = ~i_req_we;
      default:                w_legal = 1'b0;
    endcase
  end

  assign w_strb8 = {4'b0000, w_mask} << i_req_addr[1:0];
  assign w_split = |w_strb8[7:4];

`ifdef LSU_MISALIGNED_SPLIT_EN
  logic              r_split;
  logic [31:0]       r_wdata1;
  logic [3:0]        r_strb1;
  logic [31:0]       r_beat1;
  logic [63:0]       w_wdata_wide;

  assign w_wdata_wide = {32'b0, i_req_wdata} << w_shamt;
  assign w_wdata0     = w_wdata_wide[31:0];
  // Beat1 bytes sit above beat0 in the pair, so one right shift aligns both.
  assign w_word       = 32'({r_beat1, r_beat0} >> w_rshamt);
`else
  assign w_wdata0     = i_req_wdata << w_shamt;
  assign w_word       = r_beat0 >> w_rshamt;
`endif

  always_comb begin
    w_ext = w_word;
    case (r_funct3)
      3'b000:  w_ext = {{24{w_word[7]}}, w_word[7:0]};
      3'b001:  w_ext = {{16{w_word[15]}}, w_word[15:0]};
      3'b100:  w_ext = {24'b0, w_word[7:0]};
      3'b101:  w_ext = {16'b0, w_word[15:0]};
      default: w_ext = w_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= c_IDLE;
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_base   <= '0;
      r_off    <= 2'b00;
      r_wdata0 <= '0;
      r_strb0  <= 4'b0000;
      r_err    <= 1'b0;
      r_beat0  <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
      r_split  <= 1'b0;
      r_wdata1 <= '0;
      r_strb1  <= 4'b0000;
      r_beat1  <= '0;
`endif
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            r_we     <= i_req_we;
            r_funct3 <= i_req_funct3;
            r_base   <= i_req_addr[ADDR_W-1:2];
            r_off    <= i_req_addr[1:0];
            r_wdata0 <= i_req_we ? w_wdata0 : 32'b0;
            r_strb0  <= w_strb8[3:0];
            r_beat0  <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
            r_split  <= w_split;
            r_wdata1 <= i_req_we ? w_wdata_wide[63:32] : 32'b0;
            r_strb1  <= w_strb8[7:4];
            r_beat1  <= '0;
            r_err    <= ~w_legal;
            r_state  <= w_legal ? c_BEAT0 : c_RESP;
`else
            r_err    <= ~w_legal | w_split;
            if (!w_legal)
              r_state <= c_RESP;
            else if (w_split)
              r_state <= c_FAULT;
            else
              r_state <= c_BEAT0;
`endif
          end
        end
        c_BEAT0: begin
          if (i_mem_gnt) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
            if (r_we)
              r_state <= r_split ? c_BEAT1 : c_RESP;
            else
              r_state <= c_WAIT0;
`else
            r_state <= r_we ? c_RESP : c_WAIT0;
`endif
          end
        end
        c_WAIT0: begin
          if (i_mem_rvalid) begin
            r_beat0 <= i_mem_rdata;
`ifdef LSU_MISALIGNED_SPLIT_EN
            r_state <= r_split ? c_BEAT1 : c_RESP;
`else
            r_state <= c_RESP;
`endif
          end
        end
`ifdef LSU_MISALIGNED_SPLIT_EN
        c_BEAT1: begin
          if (i_mem_gnt)
            r_state <= r_we ? c_RESP : c_WAIT1;
        end
        c_WAIT1: begin
          if (i_mem_rvalid) begin
            r_beat1 <= i_mem_rdata;
            r_state <= c_RESP;
          end
        end
`else
        c_FAULT: r_state <= c_RESP;
`endif
        c_RESP:  r_state <= c_IDLE;
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // Beat fields are zero whenever no beat is presented, so reset clears them too.
  always_comb begin
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_strb  = 4'b0000;
    o_rsp_valid = 1'b0;
    o_rsp_err   = 1'b0;
    o_rsp_rdata = '0;
    case (r_state)
      c_BEAT0: begin
        o_mem_req   = 1'b1;
        o_mem_we    = r_we;
        o_mem_addr  = {r_base, 2'b00};
        o_mem_wdata = r_wdata0;
        o_mem_strb  = r_strb0;
      end
`ifdef LSU_MISALIGNED_SPLIT_EN
      c_BEAT1: begin
        o_mem_req   = 1'b1;
        o_mem_we    = r_we;
        o_mem_addr  = {r_base + (ADDR_W-2)'(1), 2'b00};
        o_mem_wdata = r_wdata1;
        o_mem_strb  = r_strb1;
      end
`endif
      c_RESP: begin
        o_rsp_valid = 1'b1;
        o_rsp_err   = r_err;
        o_rsp_rdata = (r_err || r_we) ? 32'b0 : w_ext;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_sequencer.sv
`default_nettype none
// ============================================================================
// tb_lsu_sequencer : directed cycle-exact bench for lsu_sequencer
// Revision 1.0
// ============================================================================
module tb_lsu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_strb;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lsu_sequencer u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_we     (req_we),
    .i_req_funct3 (req_funct3),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_rdata  (rsp_rdata),
    .o_rsp_err    (rsp_err),
    .o_mem_req    (mem_req),
    .o_mem_we     (mem_we),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .o_mem_strb   (mem_strb),
    .i_mem_gnt    (mem_gnt),
    .i_mem_rvalid (mem_rvalid),
    .i_mem_rdata  (mem_rdata)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    chk("ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    tick();
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
  endtask

  task automatic chk_beat(input string tag, input logic we, input logic [31:0] addr,
                          input logic [3:0] strb, input logic [31:0] wd);
    chk({tag, "_req"},  32'(mem_req), 32'd1);
    chk({tag, "_we"},   32'(mem_we), 32'(we));
    chk({tag, "_addr"}, mem_addr, addr);
    chk({tag, "_strb"}, 32'(mem_strb), 32'(strb));
    if (we) chk({tag, "_wdata"}, mem_wdata, wd);
  endtask

  task automatic chk_rsp(input string tag, input logic err, input logic [31:0] rd);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_rsp_err"},   32'(rsp_err), 32'(err));
    chk({tag, "_rsp_rdata"}, rsp_rdata, rd);
    tick();
    chk({tag, "_rsp_pulse"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_ready_after"}, 32'(req_ready), 32'd1);
  endtask

  task automatic load_aligned(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] rd, input logic [31:0] xaddr,
                              input logic [3:0] xstrb, input logic [31:0] xdata);
    issue(1'b0, f3, addr, 32'h0);
    chk_beat(tag, 1'b0, xaddr, xstrb, 32'h0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk({tag, "_wait_no_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_wait_no_rsp"}, 32'(rsp_valid), 32'd0);
    mem_rvalid = 1'b1; mem_rdata = rd;
    tick();
    mem_rvalid = 1'b0; mem_rdata = '0;
    chk_rsp(tag, 1'b0, xdata);
  endtask

  task automatic store_aligned(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wd, input int gnt_delay,
                               input logic [31:0] xaddr, input logic [3:0] xstrb,
                               input logic [31:0] xwd);
    issue(1'b1, f3, addr, wd);
    for (int i = 0; i < gnt_delay; i++) begin
      chk_beat({tag, "_hold"}, 1'b1, xaddr, xstrb, xwd);
      tick();
    end
    chk_beat(tag, 1'b1, xaddr, xstrb, xwd);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk_rsp(tag, 1'b0, 32'h0);
  endtask

  task automatic expect_err(input string tag, input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input int lat);
    issue(we, f3, addr, 32'h11223344);
    for (int i = 1; i < lat; i++) begin
      chk({tag, "_early_rsp"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_no_req"},    32'(mem_req), 32'd0);
      tick();
    end
    chk({tag, "_no_req_resp"}, 32'(mem_req), 32'd0);
    chk_rsp(tag, 1'b1, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_strb", 32'(mem_strb), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    tick();

    load_aligned("lw",  3'b010, 32'h100, 32'hDEADBEEF, 32'h100, 4'b1111, 32'hDEADBEEF);
    load_aligned("lb",  3'b000, 32'h103, 32'h80123456, 32'h100, 4'b1000, 32'hFFFFFF80);
    load_aligned("lbu", 3'b100, 32'h103, 32'h80123456, 32'h100, 4'b1000, 32'h00000080);
    load_aligned("lh",  3'b001, 32'h102, 32'h80123456, 32'h100, 4'b1100, 32'hFFFF8012);
    load_aligned("lhu", 3'b101, 32'h102, 32'h80123456, 32'h100, 4'b1100, 32'h00008012);
    load_aligned("lb0", 3'b000, 32'h101, 32'h00007F00, 32'h100, 4'b0010, 32'h0000007F);

    store_aligned("sh_delay", 3'b001, 32'h202, 32'h0000ABCD, 3, 32'h200, 4'b1100, 32'hABCD0000);
    store_aligned("sw",       3'b010, 32'h010, 32'h12345678, 0, 32'h010, 4'b1111, 32'h12345678);
    store_aligned("sb",       3'b000, 32'h011, 32'h000000AB, 0, 32'h010, 4'b0010, 32'h0000AB00);

    expect_err("ill_load011",  1'b0, 3'b011, 32'h100, 1);
    expect_err("ill_store100", 1'b1, 3'b100, 32'h100, 1);

`ifdef LSU_MISALIGNED_SPLIT_EN
    issue(1'b1, 3'b010, 32'h301, 32'h11223344);
    chk_beat("ssw_b0", 1'b1, 32'h300, 4'b1110, 32'h22334400);
    mem_gnt = 1'b1; tick();
    chk_beat("ssw_b1", 1'b1, 32'h304, 4'b0001, 32'h00000011);
    tick(); mem_gnt = 1'b0;
    chk_rsp("ssw", 1'b0, 32'h0);

    issue(1'b0, 3'b001, 32'h403, 32'h0);
    chk_beat("slh_b0", 1'b0, 32'h400, 4'b1000, 32'h0);
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hAA000000; tick(); mem_rvalid = 1'b0;
    chk_beat("slh_b1", 1'b0, 32'h404, 4'b0001, 32'h0);
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
    chk("slh_wait1_no_rsp", 32'(rsp_valid), 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h000000BB; tick(); mem_rvalid = 1'b0; mem_rdata = '0;
    chk_rsp("slh", 1'b0, 32'hFFFFBBAA);

    issue(1'b1, 3'b001, 32'hFFFFFFFF, 32'h00001234);
    chk_beat("wrap_b0", 1'b1, 32'hFFFFFFFC, 4'b1000, 32'h34000000);
    mem_gnt = 1'b1; tick();
    chk_beat("wrap_b1", 1'b1, 32'h00000000, 4'b0001, 32'h00000012);
    tick(); mem_gnt = 1'b0;
    chk_rsp("wrap", 1'b0, 32'h0);
`else
    expect_err("split_sw_fault", 1'b1, 3'b010, 32'h301, 2);
    expect_err("split_lh_fault", 1'b0, 3'b001, 32'h403, 2);
`endif

    // Reset while waiting for read data; the late rvalid must be dropped.
    issue(1'b0, 3'b010, 32'h100, 32'h0);
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("rstw_ready", 32'(req_ready), 32'd1);
    chk("rstw_no_rsp", 32'(rsp_valid), 32'd0);
    chk("rstw_no_req", 32'(mem_req), 32'd0);
    chk("rstw_addr", mem_addr, 32'h0);
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D; tick(); mem_rvalid = 1'b0; mem_rdata = '0;
    chk("rstw_late_rvalid_rsp", 32'(rsp_valid), 32'd0);
    chk("rstw_late_rvalid_ready", 32'(req_ready), 32'd1);
    tick();
    chk("rstw_still_idle", 32'(rsp_valid), 32'd0);
    load_aligned("lw_after_rst", 3'b010, 32'h104, 32'h01020304, 32'h104, 4'b1111, 32'h01020304);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
